gpio_apb_master: RTL and testbench

GPIO_APB_MASTER -- requirements
Module: gpio_apb_master

---
 rtl/gpio_apb_master.sv | 170 +++++++++++++++++
 tb/tb_gpio_apb_master.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_apb_master.sv
// APB requester bridging a single-outstanding local command/response port
// onto an APB bus. Unaligned addresses are rejected locally; stalled
// transfers can be aborted after a programmable number of wait cycles.
module gpio_apb_master #(
  parameter int TIMEOUT = 16
) (
  input  logic        PCLK,
  input  logic        PRESET,
  // local command port
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [7:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  // local response port
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout,
  // APB requester outputs
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [7:0]  PADDR,
  output logic [31:0] PWDATA,
  // APB completer returns
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR
);

  localparam int DATA_W = 32;
  // A zero TIMEOUT still needs a legal (unused) one-bit counter.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W:0] TMO_LIM = (CNT_W + 1)'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic             accept;
  logic             unaligned;
  logic             done;
  logic             tmo_hit;

  assign cmd_ready = (state == IDLE);

  // Decode the events that drive both the FSM and the response capture.
  always_comb begin
    accept    = 1'b0;
    unaligned = 1'b0;
    done      = 1'b0;
    tmo_hit   = 1'b0;
    accept    = (state == IDLE) && cmd_valid;
    unaligned = (cmd_addr[1:0] != 2'b00);
    done      = (state == ACCESS) && PREADY;
    // PREADY wins over an expiring counter, so the timeout only fires
    // on an edge where the completer is still stalling.
    if ((TIMEOUT > 0) && (state == ACCESS) && !PREADY &&
        (({1'b0, wait_cnt} + (CNT_W + 1)'(1)) == TMO_LIM)) begin
      tmo_hit = 1'b1;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = unaligned ? RESP : SETUP;
        end
      end
      SETUP: begin
        state_nxt = ACCESS;
      end
      ACCESS: begin
        if (done || tmo_hit) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Wait-state counter: restarts for every transfer, counts stalled ACCESS edges.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      wait_cnt <= '0;
    end else if (state == SETUP) begin
      wait_cnt <= '0;
    end else if ((state == ACCESS) && !PREADY) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // APB outputs: strobes follow the next state, address/data are latched on
  // acceptance and stay put for the whole transfer.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      PSEL    <= 1'b0;
      PENABLE <= 1'b0;
      PWRITE  <= 1'b0;
      PADDR   <= '0;
      PWDATA  <= '0;
    end else begin
      PSEL    <= (state_nxt == SETUP) || (state_nxt == ACCESS);
      PENABLE <= (state_nxt == ACCESS);
      if (accept) begin
        PWRITE <= cmd_write;
        PADDR  <= cmd_addr;
        PWDATA <= cmd_wdata;
      end
    end
  end

  // Response capture: fields are loaded on the edge that enters RESP and
  // held until the requester takes them.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      rsp_valid <= (state_nxt == RESP);
      if (accept && unaligned) begin
        rsp_rdata   <= '0;
        rsp_err     <= 1'b1;
        rsp_timeout <= 1'b0;
      end else if (done) begin
        rsp_rdata   <= (!PWRITE && !PSLVERR) ? PRDATA : {DATA_W{1'b0}};
        rsp_err     <= PSLVERR;
        rsp_timeout <= 1'b0;
      end else if (tmo_hit) begin
        rsp_rdata   <= '0;
        rsp_err     <= 1'b1;
        rsp_timeout <= 1'b1;
      end else if ((state == RESP) && rsp_ready) begin
        rsp_rdata   <= '0;
        rsp_err     <= 1'b0;
        rsp_timeout <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gpio_apb_master.sv
// Directed bench for gpio_apb_master: zero-wait and wait-state transfers,
// timeout and its PREADY priority, slave error, unaligned rejection,
// response backpressure and mid-transfer reset.
module tb_gpio_apb_master;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  int checks = 0;
  int errors = 0;

  gpio_apb_master #(.TIMEOUT(4)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  // Present a command for one edge; it is accepted on that edge from IDLE.
  task automatic issue(input logic wr, input logic [7:0] addr, input logic [31:0] data);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = data;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", {31'd0, rsp_valid}, 32'd0);
    chk("cmd_ready_back", {31'd0, cmd_ready}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    PRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; rsp_ready = 1'b0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;

    // Reset state, with a command offered that must not be accepted.
    #2;
    chk("rst_psel", {31'd0, PSEL}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_addr = 8'h04; cmd_wdata = 32'h11112222;
    repeat (2) step();
    chk("rst_no_accept_psel", {31'd0, PSEL}, 32'd0);
    chk("rst_no_accept_paddr", {24'd0, PADDR}, 32'd0);
    chk("rst_no_accept_pwdata", PWDATA, 32'd0);
    cmd_valid = 1'b0;
    @(negedge PCLK);
    PRESET = 1'b0;
    step();

    // Zero-wait write to 0x00.
    PREADY = 1'b1;
    issue(1'b1, 8'h00, 32'h000000FF);
    chk("zw_setup_psel", {31'd0, PSEL}, 32'd1);
    chk("zw_setup_penable", {31'd0, PENABLE}, 32'd0);
    chk("zw_setup_pwrite", {31'd0, PWRITE}, 32'd1);
    chk("zw_setup_pwdata", PWDATA, 32'h000000FF);
    chk("zw_setup_paddr", {24'd0, PADDR}, 32'h00);
    chk("zw_cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
    step();
    chk("zw_access_penable", {31'd0, PENABLE}, 32'd1);
    chk("zw_access_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    step();
    chk("zw_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("zw_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("zw_rsp_rdata", rsp_rdata, 32'd0);
    chk("zw_rsp_psel", {31'd0, PSEL}, 32'd0);
    chk("zw_rsp_penable", {31'd0, PENABLE}, 32'd0);
    take_rsp();

    // Wait-state read from 0x08: three stalled ACCESS cycles, then ready.
    PREADY = 1'b0; PRDATA = 32'hFFFF0000;
    issue(1'b0, 8'h08, 32'h0);
    chk("ws_setup_psel", {31'd0, PSEL}, 32'd1);
    step();
    for (int i = 0; i < 3; i++) begin
      chk("ws_wait_penable", {31'd0, PENABLE}, 32'd1);
      chk("ws_wait_paddr", {24'd0, PADDR}, 32'h08);
      chk("ws_wait_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      step();
    end
    chk("ws_last_penable", {31'd0, PENABLE}, 32'd1);
    chk("ws_last_paddr", {24'd0, PADDR}, 32'h08);
    PREADY = 1'b1; PRDATA = 32'hA5A500FF;
    step();
    PREADY = 1'b0;
    chk("ws_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("ws_rsp_rdata", rsp_rdata, 32'hA5A500FF);
    chk("ws_rsp_err", {31'd0, rsp_err}, 32'd0);
    take_rsp();

    // Timeout: PREADY never rises, abort after four ACCESS cycles.
    PRDATA = 32'h12345678;
    issue(1'b0, 8'h0C, 32'h0);
    step();
    n = 0;
    while (PENABLE && n < 10) begin
      n++;
      step();
    end
    chk("to_access_cycles", n, 32'd4);
    chk("to_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("to_rsp_err", {31'd0, rsp_err}, 32'd1);
    chk("to_rsp_timeout", {31'd0, rsp_timeout}, 32'd1);
    chk("to_rsp_rdata", rsp_rdata, 32'd0);
    chk("to_psel", {31'd0, PSEL}, 32'd0);
    take_rsp();

    // PREADY on the fourth ACCESS edge beats the timeout.
    issue(1'b0, 8'h0C, 32'h0);
    step();
    n = 0;
    while (PENABLE && n < 10) begin
      n++;
      if (n == 4) PREADY = 1'b1;
      step();
    end
    PREADY = 1'b0;
    chk("tp_access_cycles", n, 32'd4);
    chk("tp_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("tp_rsp_timeout", {31'd0, rsp_timeout}, 32'd0);
    chk("tp_rsp_rdata", rsp_rdata, 32'h12345678);
    take_rsp();

    // Slave error on read 0x10; rsp_ready held high early is ignored.
    PREADY = 1'b1; PSLVERR = 1'b1; PRDATA = 32'hDEADBEEF; rsp_ready = 1'b1;
    issue(1'b0, 8'h10, 32'h0);
    chk("se_early_ready_setup", {31'd0, PSEL}, 32'd1);
    step();
    step();
    chk("se_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("se_rsp_err", {31'd0, rsp_err}, 32'd1);
    chk("se_rsp_rdata", rsp_rdata, 32'd0);
    chk("se_rsp_timeout", {31'd0, rsp_timeout}, 32'd0);
    step();
    rsp_ready = 1'b0; PSLVERR = 1'b0;
    chk("se_done", {31'd0, rsp_valid}, 32'd0);

    // Unaligned address 0x06: straight to an error response, no APB cycle.
    issue(1'b0, 8'h06, 32'h0);
    chk("ua_psel", {31'd0, PSEL}, 32'd0);
    chk("ua_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("ua_rsp_err", {31'd0, rsp_err}, 32'd1);
    chk("ua_rsp_timeout", {31'd0, rsp_timeout}, 32'd0);
    chk("ua_rsp_rdata", rsp_rdata, 32'd0);
    step();
    chk("ua_psel_hold", {31'd0, PSEL}, 32'd0);
    take_rsp();

    // Backpressure: response held for 5 cycles; new commands ignored.
    PREADY = 1'b1; PRDATA = 32'h5A5A1234;
    issue(1'b0, 8'h14, 32'h0);
    step();
    step();
    PRDATA = 32'h0;
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h30;
      chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_rsp_rdata", rsp_rdata, 32'h5A5A1234);
      chk("bp_rsp_err", {31'd0, rsp_err}, 32'd0);
      chk("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      chk("bp_psel", {31'd0, PSEL}, 32'd0);
      step();
    end
    cmd_valid = 1'b0;
    take_rsp();
    chk("bp_no_queued_cmd", {31'd0, PSEL}, 32'd0);

    // Reset pulsed mid-ACCESS, then a fresh transfer.
    PREADY = 1'b0;
    issue(1'b1, 8'h24, 32'hCAFEF00D);
    step();
    chk("rm_in_access", {31'd0, PENABLE}, 32'd1);
    #2;
    PRESET = 1'b1;
    #1;
    chk("rm_psel", {31'd0, PSEL}, 32'd0);
    chk("rm_penable", {31'd0, PENABLE}, 32'd0);
    chk("rm_pwrite", {31'd0, PWRITE}, 32'd0);
    chk("rm_paddr", {24'd0, PADDR}, 32'd0);
    chk("rm_pwdata", PWDATA, 32'd0);
    chk("rm_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    PREADY = 1'b1;
    step();
    chk("rm_no_rsp", {31'd0, rsp_valid}, 32'd0);
    @(negedge PCLK);
    PRESET = 1'b0;
    step();
    chk("rm_after_no_rsp", {31'd0, rsp_valid}, 32'd0);
    PRDATA = 32'h0BADF00D;
    issue(1'b0, 8'h04, 32'h0);
    chk("rm_new_setup_psel", {31'd0, PSEL}, 32'd1);
    chk("rm_new_setup_penable", {31'd0, PENABLE}, 32'd0);
    chk("rm_new_paddr", {24'd0, PADDR}, 32'h04);
    step();
    step();
    chk("rm_new_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("rm_new_rsp_rdata", rsp_rdata, 32'h0BADF00D);
    chk("rm_new_rsp_err", {31'd0, rsp_err}, 32'd0);
    take_rsp();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
